prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Parametrised front-panel memory programmer for the CDEC8 system. Debounces a raw
//  programming push-button, writes switch data into RAM at an auto-incrementing
//  address, supports explicit address load, and optionally reads back and verifies each
//  write. Sits between the board I/O and the RAM port mux, active only in program mode.
// PARAMETERS
//  ADDR_W    8    RAM address width
//  DATA_W    8    RAM/switch data width
//  DEPTH     256  number of programmable words; 1 <= DEPTH <= 2**ADDR_W
//  DEBOUNCE  4    cycles strobe must be stable before an edge is accepted; >= 1
// PORTS
//  clock         in   1       system clock; all logic on rising edge
//  reset         in   1       synchronous reset, active-high
//  mode          in   1       1 = program mode, 0 = run mode (block idle)
//  strobe_in     in   1       raw, asynchronous programming push-button
//  cmd_set_adrs  in   1       sampled at accepted strobe: 1 = load address, 0 = write word
//  data_in       in   DATA_W  switch data
//  mem_q         in   DATA_W  RAM read data; 1-cycle synchronous read
//  mem_adrs      out  ADDR_W  RAM address, equal to current address register
//  mem_data      out  DATA_W  RAM write data, registered copy of data_in
//  mem_wr_en     out  1       RAM write enable, single-cycle pulse
//  busy          out  1       1 while FSM is not IDLE
//  wrapped       out  1       sticky: address has wrapped DEPTH-1 -> 0
//  verify_err    out  1       sticky: a readback mismatch occurred
// BEHAVIOUR
//  - Reset: address=0, mem_data=0, mem_wr_en=0, busy=0, wrapped=0, verify_err=0, FSM=IDLE.
//    Debouncer state cleared; a strobe already high at reset yields no event until
//    it has gone low and risen again.
//  - strobe_in: 2-FF sync, then debounce: a level change is accepted only after DEBOUNCE
//    consecutive stable cycles. Accepted rising level = one-cycle event (cycle E).
//  - Events are ignored when mode=0 or busy=1 (dropped, not queued).
//  - FSM states: IDLE, WRITE, WAIT, CHECK.
//    IDLE, event, cmd_set_adrs=1: load address from data_in (zero-extended/truncated to
//      ADDR_W). If value >= DEPTH, address unchanged. No write. Stay IDLE.
//    IDLE, event, cmd_set_adrs=0: latch mem_data<=data_in -> WRITE (cycle E+1).
//    WRITE: mem_wr_en=1 for exactly this cycle; mem_adrs/mem_data stable.
//  - Address increment: DEPTH-1 -> 0 and sets wrapped. Otherwise +1.
//  - mode rising edge: address, wrapped and verify_err cleared to 0.
//  - mode falling while busy: FSM -> IDLE next cycle. A pending WRITE is not issued.
//    Address is not incremented.
//  - reset asserted mid-operation overrides everything; no write pulse is issued.
// CONFIGURATION
//  PROG_VERIFY_EN defined:
//    Path: WRITE -> WAIT (E+2) -> CHECK (E+3) -> IDLE, with the address incremented at the
//    CHECK edge (new value visible at E+4).
//    In CHECK, mem_q != mem_data sets verify_err. verify_err is cleared only by reset or
//    by a mode rising edge.
//  PROG_VERIFY_EN undefined:
//    Path: WRITE -> IDLE, with the address incremented at the WRITE edge (visible at E+2).
//    WAIT and CHECK are unreachable. verify_err is tied to 0 and mem_q is unused.
// STRUCTURE
//  - Shared package prog_pkg: FSM state encodings (IDLE/WRITE/WAIT/CHECK localparams)
//    and the default DEBOUNCE value.
//  - Sub-module strobe_debouncer (param DEBOUNCE): 2-FF sync, stable counter, rise pulse.
//  - prog_loader holds the FSM, address counter, data register and sticky flags.
// TESTING
//  1. reset, mode=1, data_in=8'hA5, strobe held 10 cycles -> one mem_wr_en pulse,
//     adrs=0, data=A5; adrs then 1.
//  2. Strobe glitch high for DEBOUNCE-1 cycles -> no event, no write, busy stays 0.
//  3. cmd_set_adrs=1, data_in=8'hFE, DEPTH=256, then two writes -> writes at FE and FF;
//     address 0 afterwards; wrapped=1.
//  4. DEPTH=200, set-address with data_in=8'hC8 -> address unchanged; with 8'hC7 ->
//     address=C7.
//  5. PROG_VERIFY_EN on, RAM model corrupts mem_q -> verify_err=1 at E+4 and stays 1;
//     mode 0->1 clears it.
//  6. mode dropped at E+1 -> no mem_wr_en pulse, address unchanged, busy=0 next cycle;
//     second strobe while busy -> ignored.

Source files
------------

// File: rtl/prog_pkg.sv
// Shared definitions for the CDEC8 front-panel programmer: FSM encodings and the default debounce length.
package prog_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_WRITE_ENC = 2'd1;
  localparam logic [1:0] ST_WAIT_ENC  = 2'd2;
  localparam logic [1:0] ST_CHECK_ENC = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE_ENC,
    WRITE = ST_WRITE_ENC,
    WAIT  = ST_WAIT_ENC,
    CHECK = ST_CHECK_ENC
  } state_t;

  localparam int DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/strobe_debouncer.sv
// Synchronises and debounces the raw programming push-button; emits a one-cycle pulse
// on each accepted rising level.
module strobe_debouncer
  import prog_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic strobe_in,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Reset treats the button as already pressed, so a strobe held through reset
  // must first be accepted low before a new rising edge can count.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= strobe_in;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
        level <= sync_p1;
        cnt   <= '0;
        rise  <= sync_p1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// CDEC8 front-panel memory programmer: debounced strobe writes switch data at an
// auto-incrementing address. Define PROG_VERIFY_EN to add read-back verification.
module prog_loader
  import prog_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode,
  input  logic              strobe_in,
  input  logic              cmd_set_adrs,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_adrs,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wr_en,
  output logic              busy,
  output logic              wrapped,
  output logic              verify_err
);

  localparam logic [ADDR_W-1:0] LAST_ADRS = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] adrs;
  logic [ADDR_W-1:0] load_adrs;
  logic              load_ok;
  logic              mode_q;
  logic              mode_rise;
  logic              strobe_ev;

  function automatic logic [ADDR_W-1:0] step_adrs(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADRS) ? '0 : a + ADDR_W'(1);
  endfunction

  strobe_debouncer #(.DEBOUNCE(DEBOUNCE)) u_debouncer (
    .clock     (clock),
    .reset     (reset),
    .strobe_in (strobe_in),
    .rise      (strobe_ev)
  );

  assign load_adrs = ADDR_W'(data_in);
  assign load_ok   = ({1'b0, load_adrs} < DEPTH_V);
  assign mode_rise = mode & ~mode_q;
  assign mem_adrs  = adrs;
  assign busy      = (state != IDLE);
  // Gated so a mode drop or reset during WRITE suppresses the pulse in that same cycle.
  assign mem_wr_en = (state == WRITE) & mode & ~reset;

`ifdef PROG_VERIFY_EN
  logic verify_err_q;
  assign verify_err = verify_err_q;
`else
  logic unused_mem_q;
  assign verify_err   = 1'b0;
  assign unused_mem_q = ^mem_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      adrs     <= '0;
      mem_data <= '0;
      wrapped  <= 1'b0;
      mode_q   <= 1'b0;
`ifdef PROG_VERIFY_EN
      verify_err_q <= 1'b0;
`endif
    end else begin
      mode_q <= mode;
      if (mode_rise) begin
        adrs    <= '0;
        wrapped <= 1'b0;
`ifdef PROG_VERIFY_EN
        verify_err_q <= 1'b0;
`endif
      end
      case (state)
        IDLE: begin
          // Events are taken only once program mode is settled; anything else is dropped.
          if (strobe_ev && mode && mode_q) begin
            if (cmd_set_adrs) begin
              if (load_ok) adrs <= load_adrs;
            end else begin
              mem_data <= data_in;
              state    <= WRITE;
            end
          end
        end
        WRITE: begin
          if (!mode) begin
            state <= IDLE;
          end else begin
`ifdef PROG_VERIFY_EN
            state <= WAIT;
`else
            adrs    <= step_adrs(adrs);
            wrapped <= wrapped | (adrs == LAST_ADRS);
            state   <= IDLE;
`endif
          end
        end
`ifdef PROG_VERIFY_EN
        WAIT: begin
          state <= mode ? CHECK : IDLE;
        end
        CHECK: begin
          if (mode) begin
            if (mem_q != mem_data) verify_err_q <= 1'b1;
            adrs    <= step_adrs(adrs);
            wrapped <= wrapped | (adrs == LAST_ADRS);
          end
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: scoreboard of expected RAM writes plus address/flag model,
// covering both the default build and PROG_VERIFY_EN.
module tb_prog_loader;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clock = 1'b0;
  logic       reset, mode, strobe_in, cmd_set_adrs, corrupt;
  logic [7:0] data_in, mem_q;
  logic [7:0] mem_adrs, mem_data;
  logic       mem_wr_en, busy, wrapped, verify_err;
  logic [7:0] b_adrs, unused_b_data;
  logic       unused_b_wr, unused_b_busy, unused_b_wrapped, unused_b_verr;

  logic [7:0] ram [256];
  wr_t        sb [$];
  logic [7:0] exp_a, exp_b;
  logic       exp_wrap, exp_verr;
  int         n_pass = 0;
  int         n_fail = 0;
  int         n_total = 0;

  always #5 clock = ~clock;

  prog_loader #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .DEBOUNCE(4)) dut (
    .clock(clock), .reset(reset), .mode(mode), .strobe_in(strobe_in),
    .cmd_set_adrs(cmd_set_adrs), .data_in(data_in), .mem_q(mem_q),
    .mem_adrs(mem_adrs), .mem_data(mem_data), .mem_wr_en(mem_wr_en),
    .busy(busy), .wrapped(wrapped), .verify_err(verify_err)
  );

  prog_loader #(.ADDR_W(8), .DATA_W(8), .DEPTH(200), .DEBOUNCE(4)) dut_b (
    .clock(clock), .reset(reset), .mode(mode), .strobe_in(strobe_in),
    .cmd_set_adrs(cmd_set_adrs), .data_in(data_in), .mem_q(mem_q),
    .mem_adrs(b_adrs), .mem_data(unused_b_data), .mem_wr_en(unused_b_wr),
    .busy(unused_b_busy), .wrapped(unused_b_wrapped), .verify_err(unused_b_verr)
  );

  // RAM with 1-cycle synchronous read; corrupt flips bits on the read path
  always @(posedge clock) begin
    if (mem_wr_en) ram[mem_adrs] <= mem_data;
    mem_q <= ram[mem_adrs] ^ (corrupt ? 8'h5A : 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [7:0] model_step(input logic [7:0] a, input int depth);
    return (int'(a) == depth - 1) ? 8'h00 : a + 8'h01;
  endfunction

  always @(negedge clock) begin
    if (mem_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_wr", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_adrs", 32'(mem_adrs), 32'(e.a));
        check("wr_data", 32'(mem_data), 32'(e.d));
      end
    end
  end

  task automatic write_word(input logic [7:0] d);
    int n;
    sb.push_back(wr_t'{exp_a, d});
    data_in      = d;
    cmd_set_adrs = 1'b0;
    strobe_in    = 1'b1;
    n = 0;
    while (mem_wr_en !== 1'b1 && n < 30) begin
      tick(1);
      n++;
    end
    check("wr_pulse", 32'(mem_wr_en), 32'd1);
    check("busy_in_write", 32'(busy), 32'd1);
`ifdef PROG_VERIFY_EN
    tick(1);
    check("adrs_held_wait", 32'(mem_adrs), 32'(exp_a));
    tick(2);
    if (corrupt) exp_verr = 1'b1;
`else
    tick(1);
`endif
    exp_wrap = exp_wrap | (exp_a == 8'hFF);
    exp_a    = model_step(exp_a, 256);
    exp_b    = model_step(exp_b, 200);
    check("adrs_inc", 32'(mem_adrs), 32'(exp_a));
    check("busy_done", 32'(busy), 32'd0);
    check("wrapped", 32'(wrapped), 32'(exp_wrap));
    check("verify_err", 32'(verify_err), 32'(exp_verr));
    tick(4);
    strobe_in = 1'b0;
    tick(12);
  endtask

  task automatic set_adrs(input logic [7:0] d);
    data_in      = d;
    cmd_set_adrs = 1'b1;
    strobe_in    = 1'b1;
    tick(10);
    check("busy_set_adrs", 32'(busy), 32'd0);
    strobe_in = 1'b0;
    tick(12);
    cmd_set_adrs = 1'b0;
    if (int'(d) < 200) exp_b = d;
    exp_a = d;
    check("set_adrs", 32'(mem_adrs), 32'(exp_a));
    check("set_adrs_b", 32'(b_adrs), 32'(exp_b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    int  n;
    logic saw;
    reset = 1'b1; mode = 1'b1; strobe_in = 1'b1; cmd_set_adrs = 1'b0;
    data_in = 8'h00; corrupt = 1'b0;
    exp_a = 8'h00; exp_b = 8'h00; exp_wrap = 1'b0; exp_verr = 1'b0;
    tick(3);
    check("rst_adrs", 32'(mem_adrs), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wrapped", 32'(wrapped), 32'd0);
    check("rst_verify_err", 32'(verify_err), 32'd0);
    reset = 1'b0;

    // strobe held high through reset must not produce an event
    tick(12);
    check("held_strobe_busy", 32'(busy), 32'd0);
    check("held_strobe_adrs", 32'(mem_adrs), 32'd0);
    strobe_in = 1'b0;
    tick(12);

    // glitch one cycle short of the debounce length
    strobe_in = 1'b1;
    tick(3);
    strobe_in = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (busy) saw = 1'b1;
    end
    check("glitch_busy", 32'(saw), 32'd0);
    check("glitch_adrs", 32'(mem_adrs), 32'd0);

    write_word(8'hA5);

    set_adrs(8'hFE);
    write_word(8'h11);
    write_word(8'h22);

    set_adrs(8'hC8);
    set_adrs(8'hC7);

    // mode dropped during the WRITE cycle
    data_in = 8'h33; cmd_set_adrs = 1'b0; strobe_in = 1'b1;
    n = 0;
    while (busy !== 1'b1 && n < 30) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drop_busy_seen", 32'(busy), 32'd1);
    mode = 1'b0;
    tick(1);
    check("drop_no_wr", 32'(mem_wr_en), 32'd0);
    tick(1);
    check("drop_idle", 32'(busy), 32'd0);
    check("drop_adrs", 32'(mem_adrs), 32'(exp_a));
    strobe_in = 1'b0;
    tick(12);
    strobe_in = 1'b1;
    tick(10);
    check("run_mode_busy", 32'(busy), 32'd0);
    strobe_in = 1'b0;
    tick(12);
    check("run_mode_adrs", 32'(mem_adrs), 32'(exp_a));

    mode = 1'b1;
    tick(2);
    exp_a = 8'h00; exp_b = 8'h00; exp_wrap = 1'b0; exp_verr = 1'b0;
    check("mode_rise_adrs", 32'(mem_adrs), 32'd0);
    check("mode_rise_wrapped", 32'(wrapped), 32'd0);
    check("mode_rise_adrs_b", 32'(b_adrs), 32'd0);

    write_word(8'h44);
`ifdef PROG_VERIFY_EN
    corrupt = 1'b1;
    write_word(8'h55);
    corrupt = 1'b0;
    tick(5);
    check("verify_sticky", 32'(verify_err), 32'd1);
    write_word(8'h66);
    mode = 1'b0;
    tick(2);
    mode = 1'b1;
    tick(2);
    exp_a = 8'h00; exp_b = 8'h00; exp_verr = 1'b0;
    check("verify_cleared", 32'(verify_err), 32'd0);
    check("verify_clr_adrs", 32'(mem_adrs), 32'd0);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    if (n_fail > 0) $display("%0d comparisons disagreed", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
